// File: rtl/dlx_seq_pkg.sv
// Shared encodings for the DLX multicycle sequencer: states, instruction
// classes, PC source selects and fault codes.
package dlx_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_ERR    = 3'd6
  } seq_state_t;

  typedef enum logic [2:0] {
    CLS_NOP    = 3'd0,
    CLS_ALU    = 3'd1,
    CLS_LOAD   = 3'd2,
    CLS_STORE  = 3'd3,
    CLS_BRANCH = 3'd4,
    CLS_JUMP   = 3'd5
  } instr_class_t;

  typedef enum logic [1:0] {
    PC_SEQ = 2'd0,
    PC_BR  = 2'd1,
    PC_JMP = 2'd2
  } pc_src_t;

  typedef enum logic [1:0] {
    FLT_NONE    = 2'd0,
    FLT_TIMEOUT = 2'd1,
    FLT_ILLEGAL = 2'd2
  } fault_t;

endpackage

// File: rtl/mem_wait_timer.sv
// Consecutive memory wait-cycle counter; flags timeout when the count
// reaches MEM_TIMEOUT. Clear has priority over count.
module mem_wait_timer #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMR_W       = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic cnt_en,
  output logic timeout
);

  logic [TMR_W-1:0] cnt;

  assign timeout = (cnt == TMR_W'(MEM_TIMEOUT));

  // Holding at the limit keeps the flag stable if the caller lingers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (cnt_en && !timeout) begin
      cnt <= cnt + TMR_W'(1);
    end
  end

endmodule

// File: rtl/dlx_multicycle_seq.sv
// Multicycle FETCH/DECODE/EXEC/MEM/WB sequencer for the DLX datapath.
// Define DLX_SEQ_STALL_CNT_EN to build the memory stall cycle counter.
module dlx_multicycle_seq
  import dlx_seq_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TMR_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [2:0]  instr_class,
  input  logic        br_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_sel_data,
  output logic        ir_wr,
  output logic        reg_wr,
  output logic        mem2reg,
  output logic        pc_wr,
  output logic [1:0]  pc_src,
  output logic        instr_done,
  output logic        fault,
  output logic [1:0]  fault_code,
  output logic [15:0] stall_cnt,
  output logic [2:0]  state
);

  seq_state_t cur_st, nxt_st;
  logic [2:0] cls_q;
  fault_t     fault_q, flt_nxt;
  logic       flt_set;
  pc_src_t    pc_sel;
  logic       timeout;
  logic       tmr_clr;

  assign state      = cur_st;
  assign fault_code = fault_q;
  assign pc_src     = pc_sel;

  // Counter restarts on every completed access and on each fresh entry to
  // a memory-requesting state.
  assign tmr_clr = mem_ready ||
                   ((nxt_st != cur_st) && (nxt_st == S_FETCH || nxt_st == S_MEM));

  mem_wait_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TMR_W      (TMR_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .cnt_en (mem_req && !mem_ready),
    .timeout(timeout)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_st  <= S_IDLE;
      cls_q   <= '0;
      fault   <= 1'b0;
      fault_q <= FLT_NONE;
    end else begin
      cur_st <= nxt_st;
      if (cur_st == S_DECODE) begin
        cls_q <= instr_class;
      end
      if (flt_set) begin
        fault   <= 1'b1;
        fault_q <= flt_nxt;
      end
    end
  end

  always_comb begin
    nxt_st       = cur_st;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_sel_data = 1'b0;
    ir_wr        = 1'b0;
    reg_wr       = 1'b0;
    mem2reg      = 1'b0;
    pc_wr        = 1'b0;
    pc_sel       = PC_SEQ;
    instr_done   = 1'b0;
    flt_set      = 1'b0;
    flt_nxt      = FLT_NONE;

    case (cur_st)
      S_IDLE: begin
        if (run) nxt_st = S_FETCH;
      end
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_wr  = 1'b1;
          nxt_st = S_DECODE;
        end else if (timeout) begin
          nxt_st  = S_ERR;
          flt_set = 1'b1;
          flt_nxt = FLT_TIMEOUT;
        end
      end
      S_DECODE: begin
        case (instr_class)
          CLS_NOP: begin
            pc_wr      = 1'b1;
            instr_done = 1'b1;
          end
          CLS_JUMP: begin
            pc_wr      = 1'b1;
            pc_sel     = PC_JMP;
            instr_done = 1'b1;
          end
          CLS_ALU, CLS_LOAD, CLS_STORE, CLS_BRANCH: nxt_st = S_EXEC;
          default: begin
            nxt_st  = S_ERR;
            flt_set = 1'b1;
            flt_nxt = FLT_ILLEGAL;
          end
        endcase
      end
      S_EXEC: begin
        case (cls_q)
          CLS_ALU:             nxt_st = S_WB;
          CLS_LOAD, CLS_STORE: nxt_st = S_MEM;
          CLS_BRANCH: begin
            pc_wr      = 1'b1;
            pc_sel     = br_taken ? PC_BR : PC_SEQ;
            instr_done = 1'b1;
          end
          default: begin
            nxt_st  = S_ERR;
            flt_set = 1'b1;
            flt_nxt = FLT_ILLEGAL;
          end
        endcase
      end
      S_MEM: begin
        mem_req      = 1'b1;
        mem_sel_data = 1'b1;
        mem_we       = (cls_q == CLS_STORE);
        if (mem_ready) begin
          if (cls_q == CLS_STORE) begin
            pc_wr      = 1'b1;
            instr_done = 1'b1;
          end else begin
            nxt_st = S_WB;
          end
        end else if (timeout) begin
          nxt_st  = S_ERR;
          flt_set = 1'b1;
          flt_nxt = FLT_TIMEOUT;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        mem2reg    = (cls_q == CLS_LOAD);
        pc_wr      = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    if (instr_done) nxt_st = run ? S_FETCH : S_IDLE;
  end

`ifdef DLX_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_q <= '0;
    end else if (mem_req && !mem_ready && stall_q != '1) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_dlx_multicycle_seq.sv
// Bench for dlx_multicycle_seq: directed corner cases plus a random
// instruction stream checked against per-instruction latency/strobe rules.
module tb_dlx_multicycle_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [2:0]  instr_class;
  logic        br_taken;
  logic        mem_ready;
  logic        mem_req, mem_we, mem_sel_data, ir_wr, reg_wr, mem2reg, pc_wr;
  logic [1:0]  pc_src;
  logic        instr_done, fault;
  logic [1:0]  fault_code;
  logic [15:0] stall_cnt;
  logic [2:0]  state;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  dlx_multicycle_seq #(.MEM_TIMEOUT(15), .TMR_W(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .instr_class (instr_class),
    .br_taken    (br_taken),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_sel_data(mem_sel_data),
    .ir_wr       (ir_wr),
    .reg_wr      (reg_wr),
    .mem2reg     (mem2reg),
    .pc_wr       (pc_wr),
    .pc_src      (pc_src),
    .instr_done  (instr_done),
    .fault       (fault),
    .fault_code  (fault_code),
    .stall_cnt   (stall_cnt),
    .state       (state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; returns at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; instr_class = 3'd0; br_taken = 1'b0;
    @(negedge clk);
    #1;
    check("rst_state", 32'(state), 32'd0);
    check("rst_fault", {fault, fault_code}, 32'd0);
    check("rst_stall", 32'(stall_cnt), 32'd0);
    check("rst_strobes", {mem_req, pc_wr, instr_done, reg_wr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Zero-wait latency table from the class rules.
  function automatic int unsigned base_lat(input int unsigned cls);
    case (cls)
      0, 5:    return 2;
      4:       return 3;
      1, 3:    return 4;
      default: return 5;
    endcase
  endfunction

  // DUT is in FETCH on entry; the memory is modelled as answering after
  // wf fetch wait cycles and wm data wait cycles.
  task automatic run_instr(input int unsigned cls, input int unsigned wf,
                           input int unsigned wm, input bit br);
    int unsigned cyc = 0, fw = 0, mw = 0, we_cyc = 0;
    bit          done = 0;
    logic [1:0]  ps = '0;
    logic        rw = 0, m2r = 0, pcw = 0;
    logic [15:0] s0 = stall_cnt;
    bit          is_mem = (cls == 2 || cls == 3);
    int unsigned exp_ps, exp_stall;
    instr_class = 3'(cls);
    br_taken    = br;
    #1;
    check("start_fetch", 32'(state), 32'd1);
    while (!done && cyc < 200) begin
      if (mem_req === 1'b1) mem_ready = mem_sel_data ? (mw == wm) : (fw == wf);
      else                  mem_ready = 1'b0;
      #1;
      cyc++;
      if (mem_we) we_cyc++;
      if (mem_req && !mem_ready) begin
        if (mem_sel_data) mw++;
        else fw++;
      end
      if (instr_done) begin
        done = 1; ps = pc_src; rw = reg_wr; m2r = mem2reg; pcw = pc_wr;
      end
      @(negedge clk);
    end
    mem_ready = 1'b0;
    exp_ps = (cls == 5) ? 2 : (cls == 4 && br) ? 1 : 0;
    check("retired", 32'(done), 32'd1);
    check("latency", cyc, base_lat(cls) + wf + (is_mem ? wm : 0));
    check("pc_src", 32'(ps), exp_ps);
    check("pc_wr", 32'(pcw), 32'd1);
    check("reg_wr", 32'(rw), 32'((cls == 1 || cls == 2) ? 1 : 0));
    check("mem2reg", 32'(m2r), 32'(cls == 2 ? 1 : 0));
    check("store_cycles", we_cyc, (cls == 3) ? wm + 1 : 0);
`ifdef DLX_SEQ_STALL_CNT_EN
    exp_stall = wf + (is_mem ? wm : 0);
`else
    exp_stall = 0;
`endif
    check("stall_delta", 32'(16'(stall_cnt - s0)), exp_stall);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // ALU with a zero-wait memory: FETCH, DECODE, EXEC, WB.
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_class = 3'd1;
    tick(); #1 check("alu_s1", 32'(state), 32'd1);
    tick(); #1 check("alu_s2", 32'(state), 32'd2);
    tick(); #1 check("alu_s3", 32'(state), 32'd3);
    tick(); #1 check("alu_s5", 32'(state), 32'd5);
    check("alu_wb", {reg_wr, mem2reg, pc_wr, pc_src, instr_done}, 32'b101001);
    run = 1'b0;
    tick(); #1 check("alu_idle", 32'(state), 32'd0);

    // Fetch timeout after 16 waiting cycles.
    do_reset();
    run = 1'b1;
    tick();
    repeat (15) tick();
    #1 check("to_still_fetch", 32'(state), 32'd1);
    tick(); #1;
    check("to_err", 32'(state), 32'd6);
    check("to_fault", {fault, fault_code}, 32'b101);
    check("to_strobes", {mem_req, ir_wr, pc_wr}, 32'd0);

    // Ready arriving exactly in the timeout cycle wins.
    do_reset();
    run = 1'b1;
    tick();
    repeat (15) tick();
    mem_ready = 1'b1;
    #1 check("edge_ir_wr", 32'(ir_wr), 32'd1);
    tick(); #1;
    check("edge_decode", 32'(state), 32'd2);
    check("edge_fault", 32'(fault), 32'd0);

    // Illegal class traps to ERR; run has no effect afterwards.
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_class = 3'd7;
    tick(); tick(); #1;
    check("ill_decode_pc_wr", {pc_wr, instr_done}, 32'd0);
    tick(); #1;
    check("ill_err", 32'(state), 32'd6);
    check("ill_fault", {fault, fault_code}, 32'b110);
    run = 1'b0; tick(); run = 1'b1; tick(); tick(); #1;
    check("ill_stuck", 32'(state), 32'd6);

    // Asynchronous reset in the middle of a STORE memory access.
    do_reset();
    run = 1'b1; mem_ready = 1'b1; instr_class = 3'd3;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); #1;
    check("st_mem", {32'(state), mem_req, mem_we, mem_sel_data}, {32'd4, 3'b111});
    #2 rst = 1'b0;
    #1;
    check("st_rst_state", 32'(state), 32'd0);
    check("st_rst_strobes", {mem_req, mem_we, pc_wr, fault}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Directed LOAD with three data wait cycles, then a random stream.
    do_reset();
    run = 1'b1;
    tick();
    run_instr(2, 0, 3, 0);
    run_instr(4, 0, 0, 1);
    run_instr(4, 0, 0, 0);
    for (int i = 0; i < 40; i++) begin
      run_instr($urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 5), 1'($urandom_range(0, 1)));
    end
    check("stream_no_fault", 32'(fault), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
